// File: rtl/axi4_lite_slave_if.sv
// Flattened AXI4-Lite bus (no WSTRB/PROT) between one master and one register slave.
interface axi4_lite_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  AW_VALID;
  logic                  AW_READY;
  logic [ADDR_WIDTH-1:0] AW_ADDR;
  logic                  W_VALID;
  logic                  W_READY;
  logic [DATA_WIDTH-1:0] W_DATA;
  logic                  B_VALID;
  logic                  B_READY;
  logic [1:0]            B_RESP;
  logic                  AR_VALID;
  logic                  AR_READY;
  logic [ADDR_WIDTH-1:0] AR_ADDR;
  logic                  R_VALID;
  logic                  R_READY;
  logic [DATA_WIDTH-1:0] R_DATA;
  logic [1:0]            R_RESP;

  modport master (
    output AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY, AR_VALID, AR_ADDR, R_READY,
    input  AW_READY, W_READY, B_VALID, B_RESP, AR_READY, R_VALID, R_DATA, R_RESP
  );

  modport slave (
    input  AW_VALID, AW_ADDR, W_VALID, W_DATA, B_READY, AR_VALID, AR_ADDR, R_READY,
    output AW_READY, W_READY, B_VALID, B_RESP, AR_READY, R_VALID, R_DATA, R_RESP
  );
endinterface

// File: rtl/axi4_lite_slave.sv
// AXI4-Lite register bank: NUM_REGS x 32-bit registers, independent write and read FSMs,
// every output taken straight from a flop.
module axi4_lite_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 4
) (
  input logic               aclk,
  input logic               areset,
  axi4_lite_slave_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;

  // Every upper address bit must be zero; bits [1:0] never matter.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (a >> (IDX_W + 2)) == '0;
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[IDX_W+1:2];
  endfunction

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  w_state_t              w_state_q, w_state_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic                  aw_ready_q, aw_ready_d;
  logic                  w_ready_q, w_ready_d;
  logic                  b_valid_q, b_valid_d;
  logic [1:0]            b_resp_q, b_resp_d;

  r_state_t              r_state_q, r_state_d;
  logic                  ar_ready_q, ar_ready_d;
  logic                  r_valid_q, r_valid_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic [1:0]            r_resp_q, r_resp_d;

  logic                  aw_hs, w_hs, ar_hs;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  // Write channel: capture AW and W independently, commit once both are present.
  always_comb begin
    regs_d     = regs_q;
    w_state_d  = w_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    aw_addr_d  = aw_addr_q;
    w_data_d   = w_data_q;
    aw_ready_d = aw_ready_q;
    w_ready_d  = w_ready_q;
    b_valid_d  = b_valid_q;
    b_resp_d   = b_resp_q;
    aw_hs      = aw_ready_q && bus.AW_VALID;
    w_hs       = w_ready_q && bus.W_VALID;
    wr_addr    = aw_held_q ? aw_addr_q : bus.AW_ADDR;
    wr_data    = w_held_q ? w_data_q : bus.W_DATA;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          aw_addr_d = bus.AW_ADDR;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          w_data_d = bus.W_DATA;
        end
        if (aw_held_d && w_held_d) begin
          if (addr_ok(wr_addr)) begin
            regs_d[addr_idx(wr_addr)] = wr_data;
            b_resp_d = RESP_OKAY;
          end else begin
            b_resp_d = RESP_SLVERR;
          end
          b_valid_d  = 1'b1;
          aw_ready_d = 1'b0;
          w_ready_d  = 1'b0;
          w_state_d  = W_RESP;
        end else begin
          aw_ready_d = !aw_held_d;
          w_ready_d  = !w_held_d;
        end
      end
      W_RESP: begin
        if (bus.B_READY) begin
          b_valid_d  = 1'b0;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          aw_ready_d = 1'b1;
          w_ready_d  = 1'b1;
          w_state_d  = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read channel: samples regs_q, so a same-edge write is not yet visible.
  always_comb begin
    r_state_d  = r_state_q;
    ar_ready_d = ar_ready_q;
    r_valid_d  = r_valid_q;
    r_data_d   = r_data_q;
    r_resp_d   = r_resp_q;
    ar_hs      = ar_ready_q && bus.AR_VALID;
    unique case (r_state_q)
      R_IDLE: begin
        ar_ready_d = 1'b1;
        if (ar_hs) begin
          if (addr_ok(bus.AR_ADDR)) begin
            r_data_d = regs_q[addr_idx(bus.AR_ADDR)];
            r_resp_d = RESP_OKAY;
          end else begin
            r_data_d = '0;
            r_resp_d = RESP_SLVERR;
          end
          r_valid_d  = 1'b1;
          ar_ready_d = 1'b0;
          r_state_d  = R_DATA;
        end
      end
      R_DATA: begin
        if (bus.R_READY) begin
          r_valid_d  = 1'b0;
          ar_ready_d = 1'b1;
          r_state_d  = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // State register boundary: reset also clears the register bank and aborts any response.
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      w_state_q  <= W_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= '0;
      r_state_q  <= R_IDLE;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= '0;
    end else begin
      regs_q     <= regs_d;
      w_state_q  <= w_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      b_valid_q  <= b_valid_d;
      b_resp_q   <= b_resp_d;
      r_state_q  <= r_state_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q  <= r_valid_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
    end
  end

  assign bus.AW_READY = aw_ready_q;
  assign bus.W_READY  = w_ready_q;
  assign bus.B_VALID  = b_valid_q;
  assign bus.B_RESP   = b_resp_q;
  assign bus.AR_READY = ar_ready_q;
  assign bus.R_VALID  = r_valid_q;
  assign bus.R_DATA   = r_data_q;
  assign bus.R_RESP   = r_resp_q;
endmodule

// File: tb/tb_axi4_lite_slave.sv
// Directed bench for axi4_lite_slave: expectations queued at drive time from a register
// model, popped and compared when the B or R response appears.
module tb_axi4_lite_slave;
  logic aclk = 1'b0;
  logic areset = 1'b1;

  axi4_lite_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi4_lite_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(4)) dut (
    .aclk  (aclk),
    .areset(areset),
    .bus   (bus)
  );

  always #5 aclk = ~aclk;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];
  logic [31:0] mdl [4];

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic expect_w(input logic [31:0] a, input logic [31:0] d);
    if (a < 32'h10) begin
      mdl[a[3:2]] = d;
      exp_b.push_back(2'b00);
    end else begin
      exp_b.push_back(2'b10);
    end
  endtask

  task automatic expect_r(input logic [31:0] a);
    if (a < 32'h10) exp_r.push_back({2'b00, mdl[a[3:2]]});
    else            exp_r.push_back({2'b10, 32'h0});
  endtask

  task automatic drive_aw(input logic [31:0] a);
    bus.AW_ADDR = a; bus.AW_VALID = 1'b1;
  endtask
  task automatic drive_w(input logic [31:0] d);
    bus.W_DATA = d; bus.W_VALID = 1'b1;
  endtask
  task automatic drive_ar(input logic [31:0] a);
    bus.AR_ADDR = a; bus.AR_VALID = 1'b1;
  endtask

  // Called on a falling edge; drops each valid after the rising edge that accepts it.
  task automatic run_hs();
    int n;
    logic haw, hw, har;
    n = 0;
    while ((bus.AW_VALID || bus.W_VALID || bus.AR_VALID) && n < 20) begin
      haw = bus.AW_VALID && bus.AW_READY;
      hw  = bus.W_VALID && bus.W_READY;
      har = bus.AR_VALID && bus.AR_READY;
      @(negedge aclk);
      n++;
      if (haw) bus.AW_VALID = 1'b0;
      if (hw)  bus.W_VALID  = 1'b0;
      if (har) bus.AR_VALID = 1'b0;
    end
    chk("hs_bound", 34'(bus.AW_VALID || bus.W_VALID || bus.AR_VALID), 34'd0);
    bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0; bus.AR_VALID = 1'b0;
  endtask

  task automatic collect_b(input string tag, input int hold);
    logic [1:0] e;
    e = (exp_b.size() > 0) ? exp_b.pop_front() : 2'bxx;
    chk({tag, "_bvalid"}, 34'(bus.B_VALID), 34'd1);
    repeat (hold) begin
      @(negedge aclk);
      chk({tag, "_bhold_valid"}, 34'(bus.B_VALID), 34'd1);
      chk({tag, "_bhold_resp"}, 34'(bus.B_RESP), 34'(e));
    end
    chk({tag, "_bresp"}, 34'(bus.B_RESP), 34'(e));
    bus.B_READY = 1'b1;
    @(negedge aclk);
    bus.B_READY = 1'b0;
    chk({tag, "_bdone"}, 34'(bus.B_VALID), 34'd0);
    chk({tag, "_wready_again"}, 34'(bus.AW_READY && bus.W_READY), 34'd1);
  endtask

  task automatic collect_r(input string tag, input int hold);
    logic [33:0] e;
    e = (exp_r.size() > 0) ? exp_r.pop_front() : 34'bx;
    chk({tag, "_rvalid"}, 34'(bus.R_VALID), 34'd1);
    repeat (hold) begin
      @(negedge aclk);
      chk({tag, "_rhold_valid"}, 34'(bus.R_VALID), 34'd1);
      chk({tag, "_rhold_data"}, {bus.R_RESP, bus.R_DATA}, e);
    end
    chk({tag, "_rdata"}, {bus.R_RESP, bus.R_DATA}, e);
    bus.R_READY = 1'b1;
    @(negedge aclk);
    bus.R_READY = 1'b0;
    chk({tag, "_rdone"}, 34'(bus.R_VALID), 34'd0);
    chk({tag, "_arready_again"}, 34'(bus.AR_READY), 34'd1);
  endtask

  task automatic read_chk(input string tag, input logic [31:0] a);
    expect_r(a);
    drive_ar(a);
    run_hs();
    collect_r(tag, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.AW_VALID = 1'b0; bus.AW_ADDR = '0; bus.W_VALID = 1'b0; bus.W_DATA = '0;
    bus.B_READY = 1'b0; bus.AR_VALID = 1'b0; bus.AR_ADDR = '0; bus.R_READY = 1'b0;
    for (int i = 0; i < 4; i++) mdl[i] = '0;

    // Reset for 3 cycles, then release.
    repeat (3) @(negedge aclk);
    areset = 1'b0;
    chk("rst_ready_low", 34'({bus.AW_READY, bus.W_READY, bus.AR_READY}), 34'd0);
    chk("rst_valid_low", 34'({bus.B_VALID, bus.R_VALID}), 34'd0);
    chk("rst_resp_data", {bus.B_RESP, bus.R_RESP, bus.R_DATA[29:0]}, 34'd0);
    @(negedge aclk);
    chk("post_rst_ready", 34'({bus.AW_READY, bus.W_READY, bus.AR_READY}), 34'h7);
    chk("post_rst_valid", 34'({bus.B_VALID, bus.R_VALID}), 34'd0);
    for (int i = 0; i < 4; i++) read_chk("rst_read", 32'(4 * i));

    // Basic write then read of 0x4, AW and W together.
    expect_w(32'h4, 32'h1234_5678);
    drive_aw(32'h4); drive_w(32'h1234_5678);
    run_hs();
    collect_b("basic_wr", 0);
    read_chk("basic_rd", 32'h4);

    // AW first, W three cycles later.
    expect_w(32'h8, 32'hDEAD_BEEF);
    drive_aw(32'h8);
    run_hs();
    chk("split_aw_held", 34'({bus.AW_READY, bus.W_READY, bus.B_VALID}), 34'b010);
    repeat (2) @(negedge aclk);
    chk("split_aw_no_commit", 34'(bus.B_VALID), 34'd0);
    drive_w(32'hDEAD_BEEF);
    run_hs();
    collect_b("split_aw_first", 0);

    // W first, AW later; hold B_READY low for 5 cycles.
    expect_w(32'hC, 32'hCAFE_F00D);
    drive_w(32'hCAFE_F00D);
    run_hs();
    chk("split_w_held", 34'({bus.AW_READY, bus.W_READY, bus.B_VALID}), 34'b100);
    repeat (2) @(negedge aclk);
    drive_aw(32'hC);
    run_hs();
    collect_b("split_w_first", 5);
    read_chk("split_rd8", 32'h8);
    read_chk("split_rdC", 32'hC);

    // Out-of-range write and read; bits [1:0] ignored on an in-range read.
    expect_w(32'h10, 32'hFFFF_FFFF);
    drive_aw(32'h10); drive_w(32'hFFFF_FFFF);
    run_hs();
    collect_b("oor_wr", 0);
    for (int i = 0; i < 4; i++) read_chk("oor_unchanged", 32'(4 * i));
    read_chk("oor_rd", 32'h10);
    read_chk("oor_rd_high", 32'h8000_0004);
    read_chk("low_bits_ignored", 32'h7);

    // Read 0x8 held unacked while a write to 0x8 completes.
    expect_r(32'h8);
    drive_ar(32'h8);
    run_hs();
    expect_w(32'h8, 32'h0BAD_F00D);
    drive_aw(32'h8); drive_w(32'h0BAD_F00D);
    run_hs();
    collect_b("bp_wr", 0);
    collect_r("bp_rd_old", 4);
    read_chk("bp_rd_new", 32'h8);

    // Read address handshake and write commit to 0x4 on the same edge.
    expect_r(32'h4);
    expect_w(32'h4, 32'h5555_AAAA);
    drive_ar(32'h4); drive_aw(32'h4); drive_w(32'h5555_AAAA);
    run_hs();
    collect_b("same_edge_wr", 0);
    collect_r("same_edge_rd_old", 0);
    read_chk("same_edge_rd_new", 32'h4);

    // Reset while both responses are pending.
    expect_w(32'h0, 32'hAAAA_5555);
    expect_r(32'hC);
    drive_aw(32'h0); drive_w(32'hAAAA_5555); drive_ar(32'hC);
    run_hs();
    chk("mid_both_valid", 34'({bus.B_VALID, bus.R_VALID}), 34'b11);
    areset = 1'b1;
    @(negedge aclk);
    chk("mid_valid_drop", 34'({bus.B_VALID, bus.R_VALID}), 34'd0);
    chk("mid_ready_low", 34'({bus.AW_READY, bus.W_READY, bus.AR_READY}), 34'd0);
    areset = 1'b0;
    exp_b.delete();
    exp_r.delete();
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    @(negedge aclk);
    chk("mid_ready_back", 34'({bus.AW_READY, bus.W_READY, bus.AR_READY}), 34'h7);
    repeat (3) begin
      @(negedge aclk);
      chk("mid_no_stale", 34'({bus.B_VALID, bus.R_VALID}), 34'd0);
    end
    for (int i = 0; i < 4; i++) read_chk("mid_cleared", 32'(4 * i));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
